// File: rtl/mirfak_fetch_unit.sv
// Instruction fetch stage: drives a Wishbone-style read bus from the fetch PC and
// feeds the IF/ID pipeline register, with a one-entry buffer for stalled responses.
module mirfak_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h80000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] iwbm_addr_o,
    output logic        iwbm_cyc_o,
    output logic        iwbm_stb_o,
    input  logic [31:0] iwbm_dat_i,
    input  logic        iwbm_ack_i,
    input  logic        iwbm_err_i,
    input  logic        take_branch_i,
    input  logic [31:0] pc_bj_target_i,
    input  logic        trap_valid_i,
    input  logic [31:0] trap_pc_i,
    input  logic        ifid_enable_i,
    input  logic        ifid_clear_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic [31:0] id_instruction_o,
    output logic        id_if_exception_o,
    output logic [3:0]  id_if_xcause_o,
    output logic        id_bubble_o
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} state_t;
    typedef enum logic [1:0] {LOAD_HOLD = 2'd0, LOAD_BUBBLE = 2'd1, LOAD_ITEM = 2'd2, LOAD_BUF = 2'd3} load_t;

    state_t      state_r, next_state_s;
    load_t       load_s;
    logic [31:0] pc_r, pc_next_s;
    logic [31:0] flush_addr_r, flush_addr_next_s;
    logic [31:0] buf_pc_r, buf_instr_r;
    logic        buf_exc_r;
    logic [3:0]  buf_xcause_r;
    logic        buf_load_s;

    logic        redirect_s, misaligned_s, bus_active_s, resp_s, accept_s, item_valid_s;
    logic [31:0] target_s, item_instr_s;
    logic        item_exc_s;
    logic [3:0]  item_xcause_s;

    assign redirect_s   = trap_valid_i | take_branch_i;
    assign target_s     = trap_valid_i ? trap_pc_i : pc_bj_target_i;
    assign misaligned_s = (pc_r[1:0] != 2'b00);
    // Reset gates the bus combinationally so an in-flight cycle is abandoned at once.
    assign bus_active_s = ~rst_i & (((state_r == FETCH) & ~misaligned_s) | (state_r == FLUSH));
    assign resp_s       = bus_active_s & (iwbm_ack_i | iwbm_err_i);
    // A clear acts as a stall for the fetch side: the item waits in the buffer.
    assign accept_s     = ifid_enable_i & ~ifid_clear_i;
    assign item_valid_s = (state_r == FETCH) & (misaligned_s | resp_s);

    assign iwbm_cyc_o  = bus_active_s;
    assign iwbm_stb_o  = bus_active_s;
    assign iwbm_addr_o = (state_r == FLUSH) ? flush_addr_r : {pc_r[31:2], 2'b00};

    // Payload of the item produced in FETCH this cycle.
    always_comb begin
        item_instr_s  = NOP;
        item_exc_s    = 1'b0;
        item_xcause_s = 4'd0;
        if (misaligned_s) begin
            item_exc_s    = 1'b1;
            item_xcause_s = 4'd0;
        end else if (iwbm_err_i) begin
            item_exc_s    = 1'b1;
            item_xcause_s = 4'd1;
        end else begin
            item_instr_s  = iwbm_dat_i;
        end
    end

    // Next-state, next-PC and IF/ID load selection.
    always_comb begin
        next_state_s      = state_r;
        pc_next_s         = pc_r;
        flush_addr_next_s = flush_addr_r;
        buf_load_s        = 1'b0;
        load_s            = LOAD_HOLD;
        case (state_r)
            FETCH: begin
                if (redirect_s) begin
                    pc_next_s = target_s;
                    load_s    = LOAD_BUBBLE;
                    if (bus_active_s & ~resp_s) begin
                        next_state_s      = FLUSH;
                        flush_addr_next_s = {pc_r[31:2], 2'b00};
                    end else begin
                        next_state_s = FETCH;
                    end
                end else if (item_valid_s) begin
                    pc_next_s = pc_r + 32'd4;
                    if (accept_s) begin
                        load_s = LOAD_ITEM;
                    end else begin
                        buf_load_s   = 1'b1;
                        next_state_s = HOLD;
                        load_s       = ifid_clear_i ? LOAD_BUBBLE : LOAD_HOLD;
                    end
                end else begin
                    load_s = (ifid_clear_i | ifid_enable_i) ? LOAD_BUBBLE : LOAD_HOLD;
                end
            end
            HOLD: begin
                if (redirect_s) begin
                    pc_next_s    = target_s;
                    next_state_s = FETCH;
                    load_s       = LOAD_BUBBLE;
                end else if (accept_s) begin
                    next_state_s = FETCH;
                    load_s       = LOAD_BUF;
                end else begin
                    load_s = ifid_clear_i ? LOAD_BUBBLE : LOAD_HOLD;
                end
            end
            FLUSH: begin
                if (redirect_s) begin
                    pc_next_s = target_s;
                end else begin
                    pc_next_s = pc_r;
                end
                next_state_s = resp_s ? FETCH : FLUSH;
                load_s = (redirect_s | ifid_clear_i | ifid_enable_i) ? LOAD_BUBBLE : LOAD_HOLD;
            end
            default: begin
                next_state_s = FETCH;
                load_s       = LOAD_BUBBLE;
            end
        endcase
    end

    // Fetch state, PC and flush address registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= FETCH;
            pc_r         <= RESET_ADDR;
            flush_addr_r <= 32'd0;
        end else begin
            state_r      <= next_state_s;
            pc_r         <= pc_next_s;
            flush_addr_r <= flush_addr_next_s;
        end
    end

    // One-entry response buffer used while IF/ID is stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_pc_r     <= 32'd0;
            buf_instr_r  <= NOP;
            buf_exc_r    <= 1'b0;
            buf_xcause_r <= 4'd0;
        end else if (buf_load_s) begin
            buf_pc_r     <= pc_r;
            buf_instr_r  <= item_instr_s;
            buf_exc_r    <= item_exc_s;
            buf_xcause_r <= item_xcause_s;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_pc_o           <= 32'd0;
            id_pc4_o          <= 32'd0;
            id_instruction_o  <= NOP;
            id_if_exception_o <= 1'b0;
            id_if_xcause_o    <= 4'd0;
            id_bubble_o       <= 1'b1;
        end else begin
            case (load_s)
                LOAD_BUBBLE: begin
                    id_pc_o           <= 32'd0;
                    id_pc4_o          <= 32'd0;
                    id_instruction_o  <= NOP;
                    id_if_exception_o <= 1'b0;
                    id_if_xcause_o    <= 4'd0;
                    id_bubble_o       <= 1'b1;
                end
                LOAD_ITEM: begin
                    id_pc_o           <= pc_r;
                    id_pc4_o          <= pc_r + 32'd4;
                    id_instruction_o  <= item_instr_s;
                    id_if_exception_o <= item_exc_s;
                    id_if_xcause_o    <= item_xcause_s;
                    id_bubble_o       <= 1'b0;
                end
                LOAD_BUF: begin
                    id_pc_o           <= buf_pc_r;
                    id_pc4_o          <= buf_pc_r + 32'd4;
                    id_instruction_o  <= buf_instr_r;
                    id_if_exception_o <= buf_exc_r;
                    id_if_xcause_o    <= buf_xcause_r;
                    id_bubble_o       <= 1'b0;
                end
                default: begin
                    id_bubble_o       <= id_bubble_o;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mirfak_fetch_unit.sv
// Scoreboard bench for mirfak_fetch_unit: a program-order model predicts the stream of
// delivered instructions; a monitor process checks every IF/ID update and bus stability.
module tb_mirfak_fetch_unit;

    localparam logic [31:0] RESET_ADDR = 32'h80000000;
    localparam logic [31:0] NOP        = 32'h00000013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] iwbm_addr_o, iwbm_dat_i, pc_bj_target_i, trap_pc_i;
    logic        iwbm_cyc_o, iwbm_stb_o, iwbm_ack_i, iwbm_err_i;
    logic        take_branch_i, trap_valid_i, ifid_enable_i, ifid_clear_i;
    logic [31:0] id_pc_o, id_pc4_o, id_instruction_o;
    logic        id_if_exception_o, id_bubble_o;
    logic [3:0]  id_if_xcause_o;

    always #5 clk_i = ~clk_i;

    mirfak_fetch_unit #(.RESET_ADDR(RESET_ADDR)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .iwbm_addr_o(iwbm_addr_o), .iwbm_cyc_o(iwbm_cyc_o), .iwbm_stb_o(iwbm_stb_o),
        .iwbm_dat_i(iwbm_dat_i), .iwbm_ack_i(iwbm_ack_i), .iwbm_err_i(iwbm_err_i),
        .take_branch_i(take_branch_i), .pc_bj_target_i(pc_bj_target_i),
        .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i),
        .ifid_enable_i(ifid_enable_i), .ifid_clear_i(ifid_clear_i),
        .id_pc_o(id_pc_o), .id_pc4_o(id_pc4_o), .id_instruction_o(id_instruction_o),
        .id_if_exception_o(id_if_exception_o), .id_if_xcause_o(id_if_xcause_o),
        .id_bubble_o(id_bubble_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic [3:0]  xc;
    } item_t;

    item_t       exp_q[$];
    logic [31:0] tail_pc;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_items = 0;
    int unsigned wait_cnt = 0;
    int unsigned max_lat  = 0;
    bit          stall    = 1'b1;

    // Memory image seen by the bench's bus slave.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h80000000) return 32'h00500093;
        return {a[15:0], a[31:16]} ^ 32'h13579bdf;
    endfunction

    function automatic bit err_at(input logic [31:0] a);
        return (a == 32'h80000008) || (a[6:2] == 5'd19);
    endfunction

    // What the fetch unit must deliver for a given program-order PC.
    function automatic item_t model(input logic [31:0] pc);
        item_t it;
        it.pc = pc;
        if (pc[1:0] != 2'b00) begin
            it.instr = NOP; it.exc = 1'b1; it.xc = 4'd0;
        end else if (err_at(pc)) begin
            it.instr = NOP; it.exc = 1'b1; it.xc = 4'd1;
        end else begin
            it.instr = mem_data(pc); it.exc = 1'b0; it.xc = 4'd0;
        end
        return it;
    endfunction

    task automatic top_up();
        while (exp_q.size() < 16) begin
            exp_q.push_back(model(tail_pc));
            tail_pc = tail_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        tail_pc = pc;
        top_up();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock of stimulus; the bus slave answers active cycles after a random latency.
    task automatic step(input bit r, input bit en, input bit clr, input bit br,
                        input logic [31:0] bt, input bit tv, input logic [31:0] tp);
        bit respond;
        @(negedge clk_i);
        rst_i = r; ifid_enable_i = en; ifid_clear_i = clr;
        take_branch_i = br; pc_bj_target_i = bt; trap_valid_i = tv; trap_pc_i = tp;
        if (r) restart(RESET_ADDR);
        else if (tv || br) restart(tv ? tp : bt);
        #1;
        respond = 1'b0;
        if (iwbm_cyc_o) begin
            if (!stall && wait_cnt == 0) begin
                respond  = 1'b1;
                wait_cnt = (max_lat == 0) ? 0 : $urandom_range(max_lat, 0);
            end else if (!stall) begin
                wait_cnt--;
            end
        end else begin
            respond = ($urandom_range(9, 0) == 0);
        end
        iwbm_err_i = respond && iwbm_cyc_o && err_at(iwbm_addr_o);
        iwbm_ack_i = respond && !iwbm_err_i;
        iwbm_dat_i = (respond && iwbm_cyc_o) ? mem_data(iwbm_addr_o) : $urandom();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: judges each IF/ID update against the scoreboard and the bus for stability.
    initial begin
        logic        p_en, p_clr, p_red, p_rst, p_cyc, p_resp;
        logic [31:0] p_addr, o_pc, o_instr;
        logic        o_bub;
        item_t       e;
        forever begin
            @(posedge clk_i);
            p_en = ifid_enable_i; p_clr = ifid_clear_i; p_red = take_branch_i | trap_valid_i;
            p_rst = rst_i; p_cyc = iwbm_cyc_o; p_resp = iwbm_ack_i | iwbm_err_i; p_addr = iwbm_addr_o;
            o_pc = id_pc_o; o_instr = id_instruction_o; o_bub = id_bubble_o;
            #1;
            if (!p_rst && !rst_i) begin
                check("cyc_eq_stb", {31'd0, iwbm_stb_o}, {31'd0, iwbm_cyc_o});
                if (p_cyc && !p_resp && iwbm_cyc_o)
                    check("addr_stable", iwbm_addr_o, p_addr);
                if (p_clr || p_red) begin
                    check("flush_bubble", {31'd0, id_bubble_o}, 32'd1);
                    check("flush_pc", id_pc_o, 32'd0);
                end else if (p_en) begin
                    if (!id_bubble_o) begin
                        if (exp_q.size() == 0) begin
                            check("scoreboard_empty", 32'd0, 32'd1);
                        end else begin
                            e = exp_q.pop_front();
                            top_up();
                            n_items++;
                            check("item_pc", id_pc_o, e.pc);
                            check("item_pc4", id_pc4_o, e.pc + 32'd4);
                            check("item_instr", id_instruction_o, e.instr);
                            check("item_exc", {31'd0, id_if_exception_o}, {31'd0, e.exc});
                            check("item_xcause", {28'd0, id_if_xcause_o}, {28'd0, e.xc});
                        end
                    end else begin
                        check("bubble_pc", id_pc_o, 32'd0);
                        check("bubble_instr", id_instruction_o, NOP);
                        check("bubble_exc", {31'd0, id_if_exception_o}, 32'd0);
                    end
                end else begin
                    check("hold_pc", id_pc_o, o_pc);
                    check("hold_instr", id_instruction_o, o_instr);
                    check("hold_bubble", {31'd0, id_bubble_o}, {31'd0, o_bub});
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1; ifid_enable_i = 1'b0; ifid_clear_i = 1'b0; take_branch_i = 1'b0;
        trap_valid_i = 1'b0; pc_bj_target_i = 32'd0; trap_pc_i = 32'd0;
        iwbm_dat_i = 32'd0; iwbm_ack_i = 1'b0; iwbm_err_i = 1'b0;
        restart(RESET_ADDR);

        // Reset values.
        step(1, 0, 0, 0, 32'd0, 0, 32'd0);
        step(1, 1, 0, 0, 32'd0, 0, 32'd0);
        check("rst_cyc", {31'd0, iwbm_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, iwbm_stb_o}, 32'd0);
        check("rst_id_pc", id_pc_o, 32'd0);
        check("rst_id_pc4", id_pc4_o, 32'd0);
        check("rst_instr", id_instruction_o, NOP);
        check("rst_exc", {31'd0, id_if_exception_o}, 32'd0);
        check("rst_xcause", {28'd0, id_if_xcause_o}, 32'd0);
        check("rst_bubble", {31'd0, id_bubble_o}, 32'd1);

        // Reset in the middle of an unanswered bus cycle.
        step(0, 0, 0, 0, 32'd0, 0, 32'd0);
        check("post_rst_cyc", {31'd0, iwbm_cyc_o}, 32'd1);
        check("post_rst_addr", iwbm_addr_o, RESET_ADDR);
        #2 rst_i = 1'b1;
        restart(RESET_ADDR);
        #1 check("async_rst_cyc", {31'd0, iwbm_cyc_o}, 32'd0);
        step(1, 0, 0, 0, 32'd0, 0, 32'd0);

        // Release with ack in the same cycle.
        stall = 1'b0; max_lat = 0; wait_cnt = 0;
        step(0, 1, 0, 0, 32'd0, 0, 32'd0);
        check("first_id_pc", id_pc_o, 32'h80000000);
        check("first_id_pc4", id_pc4_o, 32'h80000004);
        check("first_instr", id_instruction_o, 32'h00500093);
        check("first_bubble", {31'd0, id_bubble_o}, 32'd0);
        check("second_addr", iwbm_addr_o, 32'h80000004);

        // Stall: response parks in the buffer, bus idles until enable returns.
        step(0, 0, 0, 0, 32'd0, 0, 32'd0);
        check("hold_cyc0", {31'd0, iwbm_cyc_o}, 32'd0);
        step(0, 0, 0, 0, 32'd0, 0, 32'd0);
        step(0, 0, 0, 0, 32'd0, 0, 32'd0);
        check("hold_cyc2", {31'd0, iwbm_cyc_o}, 32'd0);
        check("hold_id_pc", id_pc_o, 32'h80000000);
        step(0, 1, 0, 0, 32'd0, 0, 32'd0);
        check("unhold_id_pc", id_pc_o, 32'h80000004);
        check("unhold_addr", iwbm_addr_o, 32'h80000008);
        check("unhold_cyc", {31'd0, iwbm_cyc_o}, 32'd1);

        // Bus error at 80000008.
        step(0, 1, 0, 0, 32'd0, 0, 32'd0);
        check("err_exc", {31'd0, id_if_exception_o}, 32'd1);
        check("err_xcause", {28'd0, id_if_xcause_o}, 32'd1);
        check("err_instr", id_instruction_o, NOP);
        check("err_id_pc", id_pc_o, 32'h80000008);

        // Branch while a response is pending: flush the old cycle.
        stall = 1'b1;
        step(0, 1, 0, 1, 32'h80000100, 0, 32'd0);
        check("flush_addr", iwbm_addr_o, 32'h8000000C);
        check("flush_cyc", {31'd0, iwbm_cyc_o}, 32'd1);
        step(0, 1, 0, 0, 32'd0, 0, 32'd0);
        check("flush_addr2", iwbm_addr_o, 32'h8000000C);
        stall = 1'b0;
        step(0, 1, 0, 0, 32'd0, 0, 32'd0);
        check("branch_addr", iwbm_addr_o, 32'h80000100);
        check("branch_bubble", {31'd0, id_bubble_o}, 32'd1);

        // Trap beats branch.
        step(0, 1, 0, 1, 32'h80000100, 1, 32'h80000200);
        check("trap_prio_addr", iwbm_addr_o, 32'h80000200);
        step(0, 1, 0, 0, 32'd0, 0, 32'd0);
        check("trap_id_pc", id_pc_o, 32'h80000200);

        // Misaligned trap target: no bus cycle, immediate fault item.
        step(0, 1, 0, 0, 32'd0, 1, 32'h80000202);
        check("mis_cyc", {31'd0, iwbm_cyc_o}, 32'd0);
        step(0, 1, 0, 0, 32'd0, 0, 32'd0);
        check("mis_id_pc", id_pc_o, 32'h80000202);
        check("mis_exc", {31'd0, id_if_exception_o}, 32'd1);
        check("mis_xcause", {28'd0, id_if_xcause_o}, 32'd0);

        // Randomized traffic.
        max_lat = 3;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] bt, tp;
            bt = 32'h80000000 + {22'd0, 8'($urandom_range(255, 0)), 2'b00};
            tp = 32'h80000000 + {22'd0, 8'($urandom_range(255, 0)), 2'b00}
                 + (($urandom_range(3, 0) == 0) ? 32'd2 : 32'd0);
            step(0, ($urandom_range(9, 0) < 7), ($urandom_range(19, 0) == 0),
                 ($urandom_range(24, 0) == 0), bt, ($urandom_range(49, 0) == 0), tp);
        end
        check("items_delivered", {31'd0, (n_items > 300)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
